// File: rtl/argmax_stream.sv
// Streaming argmax: one class score per beat in, held {index, value, margin,
// low-confidence} result out, both sides on valid/ready handshakes.
module argmax_stream #(
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned DATA_W    = 16,
    parameter bit          SIGNED    = 1'b0,
    parameter int unsigned IDX_W     = $clog2(N_CLASSES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_score,
    input  logic [DATA_W:0]   conf_thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  max_index,
    output logic [DATA_W-1:0] max_value,
    output logic [DATA_W:0]   margin,
    output logic              low_conf
);

    localparam int unsigned EXT_W = DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_cnt;
    logic [EXT_W-1:0]   r_best;
    logic [EXT_W-1:0]   r_second;
    logic [IDX_W-1:0]   r_idx;

    logic [IDX_W-1:0]   r_max_index;
    logic [DATA_W-1:0]  r_max_value;
    logic [EXT_W-1:0]   r_margin;
    logic               r_low_conf;

    logic [EXT_W-1:0]   w_ext_score;
    logic [EXT_W-1:0]   w_min;
    logic [EXT_W-1:0]   w_best_nxt;
    logic [EXT_W-1:0]   w_second_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [EXT_W-1:0]   w_margin;
    logic               w_low_conf;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; clear overrides beats and release
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        if (clear) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (in_valid && r_in_ready) begin
                        w_accept = 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            w_last      = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        w_state_nxt = S_COLLECT;
                    end
                end
                default: w_state_nxt = S_COLLECT;
            endcase
        end
    end

    // Best/second-best update for the current beat, in sign- or zero-extended form
    always_comb begin
        w_ext_score = SIGNED ? {in_score[DATA_W-1], in_score} : {1'b0, in_score};
        w_min       = '0;
        if (SIGNED) begin
            w_min[DATA_W:DATA_W-1] = 2'b11;
        end
        w_best_nxt   = r_best;
        w_second_nxt = r_second;
        w_idx_nxt    = r_idx;
        if (r_cnt == '0) begin
            w_best_nxt   = w_ext_score;
            w_second_nxt = w_min;
            w_idx_nxt    = '0;
        end else if ($signed(w_ext_score) > $signed(r_best)) begin
            w_second_nxt = r_best;
            w_best_nxt   = w_ext_score;
            w_idx_nxt    = r_cnt;
        end else if ($signed(w_ext_score) > $signed(r_second)) begin
            w_second_nxt = w_ext_score;
        end
        w_margin   = w_best_nxt - w_second_nxt;
        w_low_conf = (w_margin < conf_thresh);
    end

    // Datapath, handshake flags and held result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_best      <= '0;
            r_second    <= '0;
            r_idx       <= '0;
            r_max_index <= '0;
            r_max_value <= '0;
            r_margin    <= '0;
            r_low_conf  <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_COLLECT);
            r_out_valid <= (w_state_nxt == S_HOLD);
            if (clear) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_best   <= w_best_nxt;
                r_second <= w_second_nxt;
                r_idx    <= w_idx_nxt;
                if (w_last) begin
                    r_cnt       <= '0;
                    r_max_index <= w_idx_nxt;
                    r_max_value <= w_best_nxt[DATA_W-1:0];
                    r_margin    <= w_margin;
                    r_low_conf  <= w_low_conf;
                end else begin
                    r_cnt <= r_cnt + IDX_W'(1);
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign max_index = r_max_index;
    assign max_value = r_max_value;
    assign margin    = r_margin;
    assign low_conf  = r_low_conf;

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: an unsigned 10x16 instance and a signed 4x8 instance
// driven with directed and random frames, checked against a plain argmax model.
module tb_argmax_stream;

    logic clk = 1'b0;
    logic reset_n;
    logic clear;

    logic        iv0, ir0, ov0, or0, lc0;
    logic [15:0] sc0, mv0;
    logic [16:0] th0, mg0;
    logic [3:0]  mi0;

    logic        iv1, ir1, ov1, or1, lc1;
    logic [7:0]  sc1, mv1;
    logic [8:0]  th1, mg1;
    logic [1:0]  mi1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    argmax_stream u_dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(iv0), .in_ready(ir0), .in_score(sc0), .conf_thresh(th0),
        .out_valid(ov0), .out_ready(or0), .max_index(mi0), .max_value(mv0),
        .margin(mg0), .low_conf(lc0)
    );

    argmax_stream #(.N_CLASSES(4), .DATA_W(8), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(iv1), .in_ready(ir1), .in_score(sc1), .conf_thresh(th1),
        .out_valid(ov1), .out_ready(or1), .max_index(mi1), .max_value(mv1),
        .margin(mg1), .low_conf(lc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index of the maximum; second-best is the max over the other entries.
    function automatic void model(input int sc[10], input int n,
                                  output int idx, output int mx, output int mg);
        int  sec;
        bit  first;
        idx = 0;
        for (int i = 1; i < n; i++) if (sc[i] > sc[idx]) idx = i;
        mx    = sc[idx];
        sec   = 0;
        first = 1'b1;
        for (int j = 0; j < n; j++) begin
            if (j != idx && (first || sc[j] > sec)) begin
                sec   = sc[j];
                first = 1'b0;
            end
        end
        mg = mx - sec;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ir0 : ir1;
    endfunction

    function automatic logic ovl(input int sel);
        return (sel == 0) ? ov0 : ov1;
    endfunction

    task automatic set_in(input int sel, input logic v, input int s);
        if (sel == 0) begin iv0 = v; sc0 = 16'(s); end
        else          begin iv1 = v; sc1 = 8'(s);  end
    endtask

    task automatic wait_accept(input int sel);
        int budget = 0;
        while (!rdy(sel) && budget < 50) begin
            tick();
            budget++;
        end
        total++;
        assert (budget < 50) else begin
            bad++;
            $error("FAIL accept_timeout: observed=in_ready_low expected=in_ready_high");
        end
        tick();
    endtask

    task automatic send_beats(input int sel, input int sc[10], input int first,
                              input int cnt, input int gap_max);
        for (int i = first; i < first + cnt; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                set_in(sel, 1'b0, int'($urandom));
                tick();
            end
            set_in(sel, 1'b1, sc[i]);
            wait_accept(sel);
        end
        set_in(sel, 1'b0, 0);
    endtask

    task automatic send_frame(input int sel, input int sc[10], input int n, input int gap_max);
        send_beats(sel, sc, 0, n - 1, gap_max);
        chk("pre_last_out_valid", 32'(ovl(sel)), 32'(0));
        send_beats(sel, sc, n - 1, 1, gap_max);
        chk("latency_out_valid", 32'(ovl(sel)), 32'(1));
        chk("hold_in_ready", 32'(rdy(sel)), 32'(0));
    endtask

    task automatic check_result(input int sel, input int sc[10], input int n, input int th);
        int idx, mx, mg;
        model(sc, n, idx, mx, mg);
        if (sel == 0) begin
            chk("u_idx",    32'(mi0), 32'(idx));
            chk("u_val",    32'(mv0), 32'(mx & 'hFFFF));
            chk("u_margin", 32'(mg0), 32'(mg));
            chk("u_low",    32'(lc0), 32'(mg < th));
        end else begin
            chk("s_idx",    32'(mi1), 32'(idx));
            chk("s_val",    32'(mv1), 32'(mx & 'hFF));
            chk("s_margin", 32'(mg1), 32'(mg));
            chk("s_low",    32'(lc1), 32'(mg < th));
        end
    endtask

    task automatic release_out(input int sel);
        if (sel == 0) or0 = 1'b1; else or1 = 1'b1;
        tick();
        if (sel == 0) or0 = 1'b0; else or1 = 1'b0;
        chk("release_out_valid", 32'(ovl(sel)), 32'(0));
        chk("release_in_ready",  32'(rdy(sel)), 32'(1));
    endtask

    task automatic rand_frame(input int sel, output int sc[10], output int th);
        bit narrow;
        narrow = 1'($urandom_range(0, 1));
        for (int i = 0; i < 10; i++) begin
            if (sel == 0) sc[i] = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
            else          sc[i] = narrow ? int'($urandom_range(0, 3)) - 2 : int'($urandom_range(0, 255)) - 128;
        end
        if (sel == 0) th = narrow ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 131071));
        else          th = narrow ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 511));
        if (sel == 0) th0 = 17'(th); else th1 = 9'(th);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(ir0), 32'(0));
        chk({tag, "_out_valid"}, 32'(ov0), 32'(0));
        chk({tag, "_max_index"}, 32'(mi0), 32'(0));
        chk({tag, "_max_value"}, 32'(mv0), 32'(0));
        chk({tag, "_margin"},    32'(mg0), 32'(0));
        chk({tag, "_low_conf"},  32'(lc0), 32'(0));
    endtask

    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_zero_outputs(tag);
        #1;
        reset_n = 1'b1;
        #1;
        chk({tag, "_ready_before_edge"}, 32'(ir0), 32'(0));
        tick();
        chk({tag, "_ready_after_edge"}, 32'(ir0), 32'(1));
    endtask

    initial begin
        int fr[10];
        int th;

        reset_n = 1'b0; clear = 1'b0;
        iv0 = 1'b0; sc0 = '0; th0 = '0; or0 = 1'b0;
        iv1 = 1'b0; sc1 = '0; th1 = '0; or1 = 1'b0;

        // Reset values, in_ready rises only on the first edge after release
        #12;
        check_zero_outputs("reset");
        chk("reset_s_in_ready", 32'(ir1), 32'(0));
        chk("reset_s_out_valid", 32'(ov1), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(ir0), 32'(0));
        tick();
        chk("rel_in_ready_high", 32'(ir0), 32'(1));
        chk("rel_s_in_ready_high", 32'(ir1), 32'(1));

        // Directed unsigned frame with a tie at the maximum
        fr = '{3, 7, 2, 9, 9, 1, 0, 4, 8, 5};
        th0 = 17'd1;
        send_frame(0, fr, 10, 0);
        chk("t1_idx", 32'(mi0), 32'd3);
        chk("t1_val", 32'(mv0), 32'd9);
        chk("t1_margin", 32'(mg0), 32'd0);
        chk("t1_low", 32'(lc0), 32'd1);

        // Backpressure: held result, beats ignored, threshold not resampled
        th0 = 17'd0;
        repeat (5) begin
            iv0 = 1'b1;
            sc0 = 16'($urandom);
            tick();
            chk("bp_out_valid", 32'(ov0), 32'd1);
            chk("bp_in_ready", 32'(ir0), 32'd0);
            chk("bp_idx", 32'(mi0), 32'd3);
            chk("bp_val", 32'(mv0), 32'd9);
            chk("bp_low", 32'(lc0), 32'd1);
        end
        iv0 = 1'b0;
        release_out(0);

        // Random unsigned frames with input gaps
        repeat (6) begin
            rand_frame(0, fr, th);
            send_frame(0, fr, 10, 3);
            check_result(0, fr, 10, th);
            release_out(0);
        end

        // Single winner at the last index, sparse valid
        fr = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        th0 = 17'd2;
        send_frame(0, fr, 10, 4);
        chk("last_idx", 32'(mi0), 32'd9);
        chk("last_margin", 32'(mg0), 32'd1);
        chk("last_low", 32'(lc0), 32'd1);
        release_out(0);

        // Clear coincident with a valid beat after four accepted beats
        fr = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
        send_beats(0, fr, 0, 4, 0);
        iv0 = 1'b1; sc0 = 16'hFFFF; clear = 1'b1;
        tick();
        clear = 1'b0; iv0 = 1'b0;
        chk("clr_in_ready", 32'(ir0), 32'd1);
        chk("clr_out_valid", 32'(ov0), 32'd0);
        chk("clr_held_idx", 32'(mi0), 32'd9);
        fr = '{5, 11, 4, 11, 2, 3, 6, 7, 1, 0};
        th0 = 17'd0;
        send_frame(0, fr, 10, 1);
        check_result(0, fr, 10, 0);

        // Clear during HOLD drops out_valid, result stays held
        or0 = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_hold_out_valid", 32'(ov0), 32'd0);
        chk("clr_hold_in_ready", 32'(ir0), 32'd1);
        check_result(0, fr, 10, 0);

        // Asynchronous reset mid-frame, then a clean frame
        rand_frame(0, fr, th);
        send_beats(0, fr, 0, 5, 1);
        pulse_reset("rst_mid");
        rand_frame(0, fr, th);
        send_frame(0, fr, 10, 2);
        check_result(0, fr, 10, th);

        // Asynchronous reset during HOLD, then a clean frame
        pulse_reset("rst_hold");
        rand_frame(0, fr, th);
        send_frame(0, fr, 10, 0);
        check_result(0, fr, 10, th);
        release_out(0);

        // Signed instance: directed frames including full-range margin
        fr = '{-5, -2, -100, -3, 0, 0, 0, 0, 0, 0};
        th1 = 9'd2;
        send_frame(1, fr, 4, 0);
        chk("s1_idx", 32'(mi1), 32'd1);
        chk("s1_val", 32'(mv1), 32'hFE);
        chk("s1_margin", 32'(mg1), 32'd1);
        chk("s1_low", 32'(lc1), 32'd1);
        release_out(1);

        fr = '{127, -128, -128, -128, 0, 0, 0, 0, 0, 0};
        th1 = 9'd0;
        send_frame(1, fr, 4, 0);
        chk("s2_idx", 32'(mi1), 32'd0);
        chk("s2_val", 32'(mv1), 32'h7F);
        chk("s2_margin", 32'(mg1), 32'd255);
        chk("s2_low", 32'(lc1), 32'd0);
        release_out(1);

        repeat (6) begin
            rand_frame(1, fr, th);
            send_frame(1, fr, 4, 2);
            check_result(1, fr, 4, th);
            release_out(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
